sort_checker: RTL

Avalon-ST sink that consumes the sorted packet stream on the source side of the sorting block and checks every packet for non-decreasing order, correct SOP/EOP framing and length within bounds. Per packet it emits a one-cycle status report and keeps saturating packet/error counters. Used as the bench-side and on-chip scoreboard for the sorter output, with optional pseudo-random backpressure to exercise the sorter's `src_ready_i` handling.

---
 rtl/sort_checker_pkg.sv | 29 ++
 rtl/lfsr_bp.sv | 26 ++
 rtl/sort_checker.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sort_checker_pkg.sv
// Shared types and constants for the sort_checker Avalon-ST scoreboard.
// Optional macro SORT_CHECKER_BACKPRESSURE_EN is consumed by sort_checker.sv.
package sort_checker_pkg;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned LFSR_W     = 16;
  localparam int unsigned STAT_LEN_W = 8;

  // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  typedef struct packed {
    logic [STAT_LEN_W-1:0] len;
    logic                  order_err;
    logic                  frame_err;
    logic                  len_err;
  } stat_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/lfsr_bp.sv
// Pseudo-random backpressure source: free-running 16-bit Galois LFSR whose
// LSB gates sink readiness.
module lfsr_bp
  import sort_checker_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst_n,
  output logic ready_bit
);

  logic [LFSR_W-1:0] lfsr;

  // Advance every cycle; a non-zero seed never reaches the all-zero lock-up state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
    end
  end

  assign ready_bit = lfsr[0];

endmodule

// File: rtl/sort_checker.sv
// Avalon-ST sink checking packets for non-decreasing order, SOP framing and
// length; emits a one-cycle status report per packet plus saturating counters.
// Optional backpressure: define SORT_CHECKER_BACKPRESSURE_EN.
module sort_checker
  import sort_checker_pkg::*;
#(
  parameter int unsigned      DWIDTH      = 8,
  parameter int unsigned      MAX_PKT_LEN = 16,
  parameter logic [15:0]      LFSR_SEED   = 16'hACE1,
  localparam int unsigned     LWIDTH      = $clog2(MAX_PKT_LEN + 2)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic              stat_valid_o,
  output logic [LWIDTH-1:0] stat_len_o,
  output logic              stat_order_err_o,
  output logic              stat_frame_err_o,
  output logic              stat_len_err_o,
  output logic [CNT_W-1:0]  pkt_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam logic [LWIDTH-1:0] LEN_MAX = LWIDTH'(MAX_PKT_LEN);
  localparam logic [LWIDTH-1:0] LEN_SAT = LWIDTH'(MAX_PKT_LEN + 1);

  state_t            state, state_n;
  logic [LWIDTH-1:0] len, len_n, len_inc;
  logic [DWIDTH-1:0] prev, prev_n;
  logic              order_err, order_err_n;
  logic              frame_err, frame_err_n;
  logic              len_err, len_err_n;
  stat_t             stat, stat_n;
  logic              stat_valid, stat_valid_n;
  logic [CNT_W-1:0]  pkt_cnt, pkt_cnt_n;
  logic [CNT_W-1:0]  err_cnt, err_cnt_n;
  logic              xfer;
  logic              done;

  // Readiness depends only on state (and the LFSR bit), never on valid
`ifdef SORT_CHECKER_BACKPRESSURE_EN
  logic bp_ready;

  lfsr_bp #(
    .SEED (LFSR_SEED)
  ) u_lfsr_bp (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .ready_bit (bp_ready)
  );

  assign snk_ready_o = (state != ST_REPORT) && bp_ready;
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign snk_ready_o = (state != ST_REPORT);
`endif

  assign xfer = snk_valid_i && snk_ready_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_IDLE;
      len        <= '0;
      prev       <= '0;
      order_err  <= 1'b0;
      frame_err  <= 1'b0;
      len_err    <= 1'b0;
      stat       <= '0;
      stat_valid <= 1'b0;
      pkt_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_n;
      len        <= len_n;
      prev       <= prev_n;
      order_err  <= order_err_n;
      frame_err  <= frame_err_n;
      len_err    <= len_err_n;
      stat       <= stat_n;
      stat_valid <= stat_valid_n;
      pkt_cnt    <= pkt_cnt_n;
      err_cnt    <= err_cnt_n;
    end
  end

  // Packet accumulation; the report is latched on the EOP beat so it is
  // visible in the REPORT cycle that follows
  always_comb begin
    state_n      = state;
    len_n        = len;
    prev_n       = prev;
    order_err_n  = order_err;
    frame_err_n  = frame_err;
    len_err_n    = len_err;
    stat_n       = stat;
    stat_valid_n = 1'b0;
    pkt_cnt_n    = pkt_cnt;
    err_cnt_n    = err_cnt;
    len_inc      = (len == LEN_SAT) ? len : len + LWIDTH'(1);
    done         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (xfer) begin
          len_n       = LWIDTH'(1);
          prev_n      = snk_data_i;
          order_err_n = 1'b0;
          frame_err_n = !snk_startofpacket_i;
          len_err_n   = (LWIDTH'(1) > LEN_MAX);
          done        = snk_endofpacket_i;
          state_n     = snk_endofpacket_i ? ST_REPORT : ST_RECV;
        end
      end
      ST_RECV: begin
        // A mid-packet SOP is flagged but otherwise treated as a data beat
        if (xfer) begin
          len_n       = len_inc;
          order_err_n = order_err | (snk_data_i < prev);
          prev_n      = snk_data_i;
          frame_err_n = frame_err | snk_startofpacket_i;
          len_err_n   = len_err | (len_inc > LEN_MAX);
          done        = snk_endofpacket_i;
          state_n     = snk_endofpacket_i ? ST_REPORT : ST_RECV;
        end
      end
      ST_REPORT: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (done) begin
      stat_valid_n     = 1'b1;
      stat_n.len       = STAT_LEN_W'(len_n);
      stat_n.order_err = order_err_n;
      stat_n.frame_err = frame_err_n;
      stat_n.len_err   = len_err_n;
      pkt_cnt_n        = sat_inc(pkt_cnt);
      if (order_err_n || frame_err_n || len_err_n) begin
        err_cnt_n = sat_inc(err_cnt);
      end
    end
  end

  assign stat_valid_o     = stat_valid;
  assign stat_len_o       = LWIDTH'(stat.len);
  assign stat_order_err_o = stat.order_err;
  assign stat_frame_err_o = stat.frame_err;
  assign stat_len_err_o   = stat.len_err;
  assign pkt_cnt_o        = pkt_cnt;
  assign err_cnt_o        = err_cnt;

endmodule
